// File: rtl/rtc_bus_sequencer.sv
// Fixed-priority arbiter and multiplexed-bus master for the external RTC chip.
// Grants one single-register access at a time and runs a full address/data cycle.
// state | meaning:  IDLE arbitrate | ADDR_SETUP/STROBE/HOLD address on bus, WRO latch strobe
//                   DATA_SETUP/STROBE/HOLD data phase, RDO or WRO strobe | RECOVER CS released
module rtc_bus_sequencer #(
  parameter int PHASE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_req,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_data,
  output logic       init_ack,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  output logic       rd_ack,
  output logic [7:0] rd_data,
  output logic       CSO,
  output logic       WRO,
  output logic       RDO,
  output logic       ADO,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_SETUP, S_ADDR_STROBE, S_ADDR_HOLD,
    S_DATA_SETUP, S_DATA_STROBE, S_DATA_HOLD, S_RECOVER
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(PHASE_CYC - 1);
  localparam logic [1:0] ID_INIT = 2'd0;
  localparam logic [1:0] ID_WR   = 2'd1;
  localparam logic [1:0] ID_RD   = 2'd2;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [1:0] r_id;
  logic       r_is_wr;
  logic [7:0] r_addr;
  logic [7:0] r_data;
  logic       r_cso, r_wro, r_rdo, r_ado, r_oe, r_busy;
  logic [7:0] r_bus_out;
  logic [7:0] r_rd_data;
  logic       r_init_ack, r_wr_ack, r_rd_ack;

  state_t     w_nxt_state;
  logic [7:0] w_nxt_cnt;
  logic [1:0] w_nxt_id;
  logic       w_nxt_wr;
  logic [7:0] w_nxt_addr;
  logic [7:0] w_nxt_data;
  logic       w_addr_ph, w_data_ph, w_ack, w_capture;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_id    = r_id;
    w_nxt_wr    = r_is_wr;
    w_nxt_addr  = r_addr;
    w_nxt_data  = r_data;
    if (r_state == S_IDLE) begin
      w_nxt_cnt = CNT_LOAD;
      if (init_req) begin
        w_nxt_state = S_ADDR_SETUP;
        w_nxt_id    = ID_INIT;
        w_nxt_wr    = 1'b1;
        w_nxt_addr  = init_addr;
        w_nxt_data  = init_data;
      end else if (wr_req) begin
        w_nxt_state = S_ADDR_SETUP;
        w_nxt_id    = ID_WR;
        w_nxt_wr    = 1'b1;
        w_nxt_addr  = wr_addr;
        w_nxt_data  = wr_data;
      end else if (rd_req) begin
        w_nxt_state = S_ADDR_SETUP;
        w_nxt_id    = ID_RD;
        w_nxt_wr    = 1'b0;
        w_nxt_addr  = rd_addr;
      end
    end else if (r_cnt == 8'd0) begin
      w_nxt_cnt   = CNT_LOAD;
      w_nxt_state = (r_state == S_RECOVER) ? S_IDLE : state_t'(r_state + 3'd1);
    end else begin
      w_nxt_cnt = r_cnt - 8'd1;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  assign w_addr_ph = (w_nxt_state == S_ADDR_SETUP) || (w_nxt_state == S_ADDR_STROBE) ||
                     (w_nxt_state == S_ADDR_HOLD);
  assign w_data_ph = (w_nxt_state == S_DATA_SETUP) || (w_nxt_state == S_DATA_STROBE) ||
                     (w_nxt_state == S_DATA_HOLD);
  assign w_ack     = (w_nxt_state == S_DATA_HOLD) && (w_nxt_cnt == 8'd0);
  assign w_capture = (r_state == S_DATA_STROBE) && (r_cnt == 8'd0) && !r_is_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_id       <= ID_INIT;
      r_is_wr    <= 1'b0;
      r_addr     <= 8'd0;
      r_data     <= 8'd0;
      r_cso      <= 1'b1;
      r_wro      <= 1'b1;
      r_rdo      <= 1'b1;
      r_ado      <= 1'b1;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
      r_bus_out  <= 8'd0;
      r_rd_data  <= 8'd0;
      r_init_ack <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_rd_ack   <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      r_id       <= w_nxt_id;
      r_is_wr    <= w_nxt_wr;
      r_addr     <= w_nxt_addr;
      r_data     <= w_nxt_data;
      r_cso      <= (w_nxt_state == S_IDLE) || (w_nxt_state == S_RECOVER);
      r_ado      <= !w_addr_ph;
      r_wro      <= !((w_nxt_state == S_ADDR_STROBE) || ((w_nxt_state == S_DATA_STROBE) && w_nxt_wr));
      r_rdo      <= !((w_nxt_state == S_DATA_STROBE) && !w_nxt_wr);
      r_oe       <= w_addr_ph || (w_data_ph && w_nxt_wr);
      r_bus_out  <= w_addr_ph ? w_nxt_addr : ((w_data_ph && w_nxt_wr) ? w_nxt_data : 8'd0);
      r_busy     <= (w_nxt_state != S_IDLE);
      r_init_ack <= w_ack && (w_nxt_id == ID_INIT);
      r_wr_ack   <= w_ack && (w_nxt_id == ID_WR);
      r_rd_ack   <= w_ack && (w_nxt_id == ID_RD);
      if (w_capture) r_rd_data <= bus_in;
    end
  end

  assign CSO      = r_cso;
  assign WRO      = r_wro;
  assign RDO      = r_rdo;
  assign ADO      = r_ado;
  assign bus_oe   = r_oe;
  assign bus_out  = r_bus_out;
  assign busy     = r_busy;
  assign rd_data  = r_rd_data;
  assign init_ack = r_init_ack;
  assign wr_ack   = r_wr_ack;
  assign rd_ack   = r_rd_ack;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: directed bus-cycle timing at P=4 plus random traffic
// at P=4 and P=1 against a timeline model of the transaction.
module tb_rtc_bus_sequencer;

  logic clk;
  logic reset;
  logic [1:0]       init_req, wr_req, rd_req;
  logic [1:0][7:0]  init_addr, init_data, wr_addr, wr_data, rd_addr, bus_in;
  logic [1:0]       init_ack, wr_ack, rd_ack, cso, wro, rdo, ado, bus_oe, busy;
  logic [1:0][7:0]  rd_data, bus_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic rand_en = 1'b0;
  logic rd_fix  = 1'b0;

  // Model: offset of the current cycle from the grant (0 = idle), plus latched request.
  int         m_off[2];
  int         m_id[2];
  logic       m_wr[2];
  logic [7:0] m_addr[2];
  logic [7:0] m_data[2];
  logic [7:0] m_rdd[2];

  rtc_bus_sequencer #(.PHASE_CYC(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .init_req(init_req[0]), .init_addr(init_addr[0]), .init_data(init_data[0]), .init_ack(init_ack[0]),
    .wr_req(wr_req[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_ack(wr_ack[0]),
    .rd_req(rd_req[0]), .rd_addr(rd_addr[0]), .rd_ack(rd_ack[0]), .rd_data(rd_data[0]),
    .CSO(cso[0]), .WRO(wro[0]), .RDO(rdo[0]), .ADO(ado[0]),
    .bus_out(bus_out[0]), .bus_oe(bus_oe[0]), .bus_in(bus_in[0]), .busy(busy[0])
  );

  rtc_bus_sequencer #(.PHASE_CYC(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .init_req(init_req[1]), .init_addr(init_addr[1]), .init_data(init_data[1]), .init_ack(init_ack[1]),
    .wr_req(wr_req[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_ack(wr_ack[1]),
    .rd_req(rd_req[1]), .rd_addr(rd_addr[1]), .rd_ack(rd_ack[1]), .rd_data(rd_data[1]),
    .CSO(cso[1]), .WRO(wro[1]), .RDO(rdo[1]), .ADO(ado[1]),
    .bus_out(bus_out[1]), .bus_oe(bus_oe[1]), .bus_in(bus_in[1]), .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_off[k] = 0;
      m_id[k]  = 3;
      m_wr[k]  = 1'b0;
      m_rdd[k] = 8'd0;
    end
  endtask

  task automatic model_step();
    int p;
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? 4 : 1;
      if (m_off[k] == 5 * p && !m_wr[k]) m_rdd[k] = bus_in[k];
      if (m_off[k] == 0) begin
        if (init_req[k]) begin
          m_id[k] = 0; m_wr[k] = 1'b1; m_addr[k] = init_addr[k]; m_data[k] = init_data[k]; m_off[k] = 1;
        end else if (wr_req[k]) begin
          m_id[k] = 1; m_wr[k] = 1'b1; m_addr[k] = wr_addr[k]; m_data[k] = wr_data[k]; m_off[k] = 1;
        end else if (rd_req[k]) begin
          m_id[k] = 2; m_wr[k] = 1'b0; m_addr[k] = rd_addr[k]; m_off[k] = 1;
        end
      end else if (m_off[k] == 7 * p) begin
        m_off[k] = 0;
      end else begin
        m_off[k] = m_off[k] + 1;
      end
    end
  endtask

  task automatic model_check();
    int p, ph, ack_id;
    logic e_oe;
    for (int k = 0; k < 2; k++) begin
      p      = (k == 0) ? 4 : 1;
      ph     = (m_off[k] == 0) ? 7 : (m_off[k] - 1) / p;
      ack_id = (m_off[k] == 6 * p) ? m_id[k] : 3;
      e_oe   = (ph <= 2) || (ph >= 3 && ph <= 5 && m_wr[k]);
      check_val($sformatf("m_cso%0d", k), cso[k], ph >= 6);
      check_val($sformatf("m_ado%0d", k), ado[k], ph > 2);
      check_val($sformatf("m_wro%0d", k), wro[k], !(ph == 1 || (ph == 4 && m_wr[k])));
      check_val($sformatf("m_rdo%0d", k), rdo[k], !(ph == 4 && !m_wr[k]));
      check_val($sformatf("m_oe%0d", k), bus_oe[k], e_oe);
      if (ph <= 2) check_val($sformatf("m_aout%0d", k), bus_out[k], m_addr[k]);
      else if (e_oe) check_val($sformatf("m_dout%0d", k), bus_out[k], m_data[k]);
      else if (ph == 7) check_val($sformatf("m_iout%0d", k), bus_out[k], 0);
      check_val($sformatf("m_busy%0d", k), busy[k], ph != 7);
      check_val($sformatf("m_iack%0d", k), init_ack[k], ack_id == 0);
      check_val($sformatf("m_wack%0d", k), wr_ack[k], ack_id == 1);
      check_val($sformatf("m_rack%0d", k), rd_ack[k], ack_id == 2);
      check_val($sformatf("m_rdat%0d", k), rd_data[k], m_rdd[k]);
      check_val($sformatf("inv_rw%0d", k), !rdo[k] && !wro[k], 0);
      check_val($sformatf("inv_cs%0d", k), (!rdo[k] || !wro[k]) && cso[k], 0);
      check_val($sformatf("inv_oe%0d", k), !rdo[k] && bus_oe[k], 0);
      check_val($sformatf("inv_ack%0d", k), $countones({init_ack[k], wr_ack[k], rd_ack[k]}) > 1, 0);
    end
  endtask

  task automatic drive_step();
    for (int k = 0; k < 2; k++) begin
      if (init_req[k] && init_ack[k]) init_req[k] = 1'b0;
      if (wr_req[k] && wr_ack[k])     wr_req[k]   = 1'b0;
      if (rd_req[k] && rd_ack[k])     rd_req[k]   = 1'b0;
      if (rand_en) begin
        if (!init_req[k] && $urandom_range(0, 11) == 0) begin
          init_req[k] = 1'b1; init_addr[k] = 8'($urandom); init_data[k] = 8'($urandom);
        end
        if (!wr_req[k] && $urandom_range(0, 7) == 0) begin
          wr_req[k] = 1'b1; wr_addr[k] = 8'($urandom); wr_data[k] = 8'($urandom);
        end
        if (!rd_req[k] && $urandom_range(0, 5) == 0) begin
          rd_req[k] = 1'b1; rd_addr[k] = 8'($urandom);
        end
      end
      bus_in[k] = (rd_fix && !rdo[k]) ? 8'h59 : 8'($urandom);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else model_step();
    @(negedge clk);
    model_check();
    drive_step();
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_val({tag, "_ctl"}, {cso[k], wro[k], rdo[k], ado[k]}, 4'hF);
      check_val({tag, "_oe"}, bus_oe[k], 0);
      check_val({tag, "_out"}, bus_out[k], 0);
      check_val({tag, "_busy"}, busy[k], 0);
      check_val({tag, "_acks"}, {init_ack[k], wr_ack[k], rd_ack[k]}, 0);
    end
  endtask

  initial begin
    reset = 1'b0;
    init_req = '0; wr_req = '0; rd_req = '0;
    init_addr = '0; init_data = '0; wr_addr = '0; wr_data = '0; rd_addr = '0; bus_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("rst0");
    check_val("rst0_rdat", rd_data, 0);
    reset = 1'b1;
    repeat (2) tick();

    // single write
    wr_req[0] = 1'b1; wr_addr[0] = 8'h21; wr_data[0] = 8'h45;
    for (int n = 1; n <= 30; n++) begin
      tick();
      check_val("wr_wro", wro[0], !((n >= 5 && n <= 8) || (n >= 17 && n <= 20)));
      if (n <= 12) begin
        check_val("wr_ado", ado[0], 0);
        check_val("wr_aout", bus_out[0], 8'h21);
      end
      if (n >= 17 && n <= 20) check_val("wr_dout", bus_out[0], 8'h45);
      check_val("wr_ack", wr_ack[0], n == 24);
      check_val("wr_busy", busy[0], n <= 28);
    end

    // single read
    rd_fix = 1'b1;
    rd_req[0] = 1'b1; rd_addr[0] = 8'h23;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n <= 12) check_val("rd_aout", bus_out[0], 8'h23);
      if (n >= 13 && n <= 24) check_val("rd_oe", bus_oe[0], 0);
      check_val("rd_rdo", rdo[0], !(n >= 17 && n <= 20));
      check_val("rd_ack", rd_ack[0], n == 24);
      if (n >= 24) check_val("rd_data", rd_data[0], 8'h59);
    end
    rd_fix = 1'b0;

    // priority: all three at once
    init_req[0] = 1'b1; init_addr[0] = 8'h0B; init_data[0] = 8'h86;
    wr_req[0]   = 1'b1; wr_addr[0]   = 8'h0A; wr_data[0]   = 8'h26;
    rd_req[0]   = 1'b1; rd_addr[0]   = 8'h00;
    for (int n = 1; n <= 90; n++) begin
      tick();
      check_val("pri_iack", init_ack[0], n == 24);
      check_val("pri_wack", wr_ack[0], n == 53);
      check_val("pri_rack", rd_ack[0], n == 82);
    end

    // late arrival: rd waits, re-asserted wr wins the next IDLE
    wr_req[0] = 1'b1; wr_addr[0] = 8'h31; wr_data[0] = 8'h17;
    for (int n = 1; n <= 90; n++) begin
      tick();
      if (n == 5) begin rd_req[0] = 1'b1; rd_addr[0] = 8'h32; end
      if (n == 26) begin wr_req[0] = 1'b1; wr_addr[0] = 8'h33; wr_data[0] = 8'h99; end
      check_val("late_wack", wr_ack[0], n == 24 || n == 53);
      check_val("late_rack", rd_ack[0], n == 82);
    end

    // reset in the middle of ADDR_STROBE
    wr_req[0] = 1'b1; wr_addr[0] = 8'h44; wr_data[0] = 8'h55;
    for (int n = 1; n <= 6; n++) tick();
    check_val("pre_rst_wro", wro[0], 0);
    reset = 1'b0;
    #1;
    check_reset_state("rst1");
    wr_req[0] = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      check_val("post_rst_busy", busy[0], 0);
      check_val("post_rst_ack", wr_ack[0], 0);
    end

    // random traffic on both phase lengths
    rand_en = 1'b1;
    repeat (4000) tick();
    rand_en = 1'b0;
    repeat (200) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Bus master and arbiter between the clock-display controller logic and the external real-time-clock chip's multiplexed address/data bus. It accepts single-register access requests from three requesters: power-up initializer, configuration writer and periodic time reader. It grants one request at a time by fixed priority and runs one complete Intel-style multiplexed bus cycle on CSO/WRO/RDO/ADO and the 8-bit bus. The top level owns the tristate buffer for Bus_Dato_Dire; this block drives `bus_out`/`bus_oe` and samples `bus_in`.

## Interface

Parameters:
- `PHASE_CYC`, default 4: clock cycles per bus phase. Legal range 1..255.

Ports:
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `init_req` in 1: initializer write request. Level; held until `init_ack`.
- `init_addr` in 8, `init_data` in 8: initializer register address and write data.
- `init_ack` out 1: one-cycle pulse, initializer write done.
- `wr_req` in 1, `wr_addr` in 8, `wr_data` in 8, `wr_ack` out 1: same contract as the initializer, for the configuration writer.
- `rd_req` in 1, `rd_addr` in 8: periodic reader read request and address.
- `rd_ack` out 1: one-cycle pulse, read done.
- `rd_data` out 8: last byte read. Held until the next read completes.
- `CSO`, `WRO`, `RDO`, `ADO` out 1 each: chip select, write strobe, read strobe, address/data select. All active-low, except ADO: 0 = address phase, 1 = data phase.
- `bus_out` out 8, `bus_oe` out 1, `bus_in` in 8: split view of the bidirectional bus.
- `busy` out 1: high in every non-IDLE state.

## Operation

- States: IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, DATA_SETUP, DATA_STROBE, DATA_HOLD, RECOVER.
- Every non-IDLE state lasts exactly PHASE_CYC cycles, timed by a phase counter. The FSM then moves to the next state in the listed order, and RECOVER returns to IDLE.
- Arbitration happens only in IDLE. Priority is init > wr > rd.
- On the grant edge the FSM latches the winner's id, address and write data, and the read/write kind. Requester inputs are ignored until the next IDLE.
- Output levels per state:
  - IDLE: CSO=1, WRO=1, RDO=1, ADO=1, bus_oe=0, bus_out=0.
  - ADDR_SETUP: CSO=0, ADO=0, bus_oe=1, bus_out=address.
  - ADDR_STROBE: as ADDR_SETUP plus WRO=0.
  - ADDR_HOLD: WRO=1; address still driven.
  - DATA_SETUP: ADO=1. On a write, bus_oe=1 and bus_out=data. On a read, bus_oe=0.
  - DATA_STROBE: write drives WRO=0; read drives RDO=0.
  - DATA_HOLD: strobes high, CSO=0, bus state unchanged from DATA_SETUP.
  - RECOVER: CSO=1, ADO=1, bus_oe=0.
- Read capture: `bus_in` is registered on the last cycle of DATA_STROBE, while RDO is still 0. `rd_data` updates on the following edge.
- Ack: the granted requester's ack is high for exactly the last cycle of DATA_HOLD. Only one ack is ever high at a time.
- A requester drops its req at the latest on the edge after ack. A req still high when the FSM reaches IDLE is a new request.
- At most one of RDO/WRO is low at any time. Neither is ever low while CSO=1. bus_oe=0 whenever RDO=0.

## Timing

- Reset asserted (mid-transaction included), effective immediately:
  - FSM goes to IDLE.
  - CSO=WRO=RDO=ADO=1, bus_oe=0, bus_out=0, rd_data=0.
  - All acks=0, busy=0.
  - The aborted transaction is never acked and never resumed.
- Grant latency: a req seen high in IDLE at edge 0 gives ADDR_SETUP from edge 1.
- With grant at cycle 0 and P=PHASE_CYC:
  - ADDR_SETUP occupies cycles 1..P.
  - ADDR_STROBE occupies P+1..2P, and so on for each state in order.
  - RECOVER occupies 6P+1..7P.
  - IDLE at 7P+1.
  - ack at cycle 6P.
  - read sample at cycle 5P.
- Back-to-back transactions: one per 7P+1 cycles (29 cycles at P=4).
- Requests raised during a transaction wait. The highest-priority req high in the next IDLE cycle wins.
- PHASE_CYC=1: each state is exactly one cycle; the sequence is unchanged.

## Test plan

- Reset: assert `reset`=0 mid ADDR_STROBE. Required: CSO/WRO/RDO/ADO=1, bus_oe=0 before the next edge; no ack; after release, busy=0.
- Single write: P=4, wr_req, wr_addr=0x21, wr_data=0x45. Required:
  - ADO=0, bus_out=0x21 over cycles 1..12, with WRO=0 over 5..8.
  - WRO=0 over 17..20 with bus_out=0x45.
  - wr_ack only at cycle 24; IDLE at 29.
- Single read: rd_addr=0x23, bench drives bus_in=0x59 while RDO=0. Required: bus_oe=0 over 13..24, RDO=0 over 17..20, rd_data=0x59 by cycle 24, rd_ack at 24, rd_data holds after.
- Priority: init_req, wr_req and rd_req all high in IDLE. Required: grant order init, wr, rd; acks at cycles 24, 53, 82; never two acks together.
- Late arrival: rd_req rises during a wr transaction, then wr_req is re-asserted before IDLE. Required: wr served again before rd.
- Invariant checks on every cycle at P=1 and P=4 random traffic:
  - RDO and WRO never both 0.
  - No strobe while CSO=1.
  - bus_oe=0 whenever RDO=0.
